// File: rtl/date_time_set_if.sv
// Bundle for the date/time setting controller: debounced buttons and current
// date values in, one-hot counter strobes and edit-status flags out.
interface date_time_set_if;
   logic       btn_set;
   logic       btn_up;
   logic       btn_down;
   logic [7:0] day_bin;
   logic [7:0] month_bin;
   logic [7:0] year_bin;
   logic [4:0] cnt_en;
   logic       cnt_up;
   logic       cnt_down;
   logic [2:0] field_sel;
   logic       blink;
   logic       editing;
   logic       commit;

   // Environment side: buttons, RTC counters and display.
   modport master (
      output btn_set, btn_up, btn_down, day_bin, month_bin, year_bin,
      input  cnt_en, cnt_up, cnt_down, field_sel, blink, editing, commit
   );

   // Controller side.
   modport slave (
      input  btn_set, btn_up, btn_down, day_bin, month_bin, year_bin,
      output cnt_en, cnt_up, cnt_down, field_sel, blink, editing, commit
   );
endinterface

// File: rtl/date_time_set_ctrl.sv
// Edit-mode sequencer for the RTC setting counters: one strobe per button edge,
// day clamped to month length after month/year edits, commit pulse on exit.
// Optional feature macro: AUTO_REPEAT_EN (held up/down auto-repeat).
module date_time_set_ctrl #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BLINK_HZ   = 2
`ifdef AUTO_REPEAT_EN
   ,
   parameter int REPEAT_DLY = 50_000_000,
   parameter int REPEAT_PER = 10_000_000
`endif
) (
   input logic            clk,
   input logic            rst,
   date_time_set_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE, S_MIN, S_HOUR, S_DAY, S_MONTH, S_YEAR, CHK, FIX, FIX_WAIT, COMMIT
   } state_t;

   localparam int BLINK_TGL = (CLK_HZ / (2 * BLINK_HZ) > 1) ? CLK_HZ / (2 * BLINK_HZ) : 1;
   localparam int BW        = (BLINK_TGL > 1) ? $clog2(BLINK_TGL) : 1;

   state_t        state, next_state;
   logic          chk_from_year, chk_from_year_d;
   logic          set_q, up_q, down_q;
   logic          set_edge, up_edge, down_edge;
   logic          up_fire, down_fire;
   logic          in_field;
   logic [7:0]    dim;
   logic [BW-1:0] blink_cnt, blink_cnt_d;

   logic [4:0]    cnt_en_q, cnt_en_d;
   logic          cnt_up_q, cnt_up_d;
   logic          cnt_down_q, cnt_down_d;
   logic [2:0]    field_sel_q, field_sel_d;
   logic          blink_q, blink_d;
   logic          editing_q, editing_d;
   logic          commit_q, commit_d;

   function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
      logic [7:0] d;
      case (m)
         8'd2:                    d = ((y % 8'd4) == 8'd0) ? 8'd29 : 8'd28;
         8'd4, 8'd6, 8'd9, 8'd11: d = 8'd30;
         default:                 d = 8'd31;
      endcase
      return d;
   endfunction

   function automatic logic [2:0] field_of(input state_t s);
      logic [2:0] f;
      case (s)
         S_MIN:   f = 3'd1;
         S_HOUR:  f = 3'd2;
         S_DAY:   f = 3'd3;
         S_MONTH: f = 3'd4;
         S_YEAR:  f = 3'd5;
         default: f = 3'd0;
      endcase
      return f;
   endfunction

   function automatic logic [4:0] onehot_of(input state_t s);
      logic [4:0] o;
      case (s)
         S_MIN:   o = 5'b00001;
         S_HOUR:  o = 5'b00010;
         S_DAY:   o = 5'b00100;
         S_MONTH: o = 5'b01000;
         S_YEAR:  o = 5'b10000;
         default: o = 5'b00000;
      endcase
      return o;
   endfunction

   assign set_edge  = bus.btn_set  & ~set_q;
   assign up_edge   = bus.btn_up   & ~up_q;
   assign down_edge = bus.btn_down & ~down_q;
   assign in_field  = (field_of(state) != 3'd0);
   assign dim       = days_in_month(bus.month_bin, bus.year_bin);

`ifdef AUTO_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int RW      = $clog2(REP_MAX + 1);

   logic [RW-1:0] rep_cnt, rep_limit;
   logic          rep_armed, rep_hold, rep_hit;

   // A single button held past its edge counts toward the initial delay,
   // then toward each repeat period; any change of field or buttons restarts it.
   assign rep_hold  = in_field && !set_edge &&
                      ((bus.btn_up & up_q & ~bus.btn_down) | (bus.btn_down & down_q & ~bus.btn_up));
   assign rep_limit = rep_armed ? RW'(REPEAT_PER) : RW'(REPEAT_DLY);
   assign rep_hit   = rep_hold && (rep_cnt == rep_limit);
   assign up_fire   = up_edge   | (rep_hit & bus.btn_up);
   assign down_fire = down_edge | (rep_hit & bus.btn_down);

   always_ff @(posedge clk) begin
      if (rst || !in_field || set_edge || (next_state != state) || !(bus.btn_up ^ bus.btn_down)) begin
         rep_cnt   <= '0;
         rep_armed <= 1'b0;
      end else if (up_edge || down_edge) begin
         rep_cnt   <= RW'(1);
         rep_armed <= 1'b0;
      end else if (rep_hit) begin
         rep_cnt   <= RW'(1);
         rep_armed <= 1'b1;
      end else if (rep_hold) begin
         rep_cnt   <= rep_cnt + 1'b1;
      end
   end
`else
   assign up_fire   = up_edge;
   assign down_fire = down_edge;
`endif

   // State, edge history, blink timer and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         chk_from_year <= 1'b0;
         set_q         <= 1'b0;
         up_q          <= 1'b0;
         down_q        <= 1'b0;
         blink_cnt     <= '0;
         cnt_en_q      <= '0;
         cnt_up_q      <= 1'b0;
         cnt_down_q    <= 1'b0;
         field_sel_q   <= '0;
         blink_q       <= 1'b0;
         editing_q     <= 1'b0;
         commit_q      <= 1'b0;
      end else begin
         state         <= next_state;
         chk_from_year <= chk_from_year_d;
         set_q         <= bus.btn_set;
         up_q          <= bus.btn_up;
         down_q        <= bus.btn_down;
         blink_cnt     <= blink_cnt_d;
         cnt_en_q      <= cnt_en_d;
         cnt_up_q      <= cnt_up_d;
         cnt_down_q    <= cnt_down_d;
         field_sel_q   <= field_sel_d;
         blink_q       <= blink_d;
         editing_q     <= editing_d;
         commit_q      <= commit_d;
      end
   end

   // Field walk; month and year exits detour through the day-length check,
   // which remembers where to resume.
   always_comb begin
      next_state      = state;
      chk_from_year_d = chk_from_year;
      case (state)
         IDLE:    if (set_edge) next_state = S_MIN;
         S_MIN:   if (set_edge) next_state = S_HOUR;
         S_HOUR:  if (set_edge) next_state = S_DAY;
         S_DAY:   if (set_edge) next_state = S_MONTH;
         S_MONTH: if (set_edge) begin
                     next_state      = CHK;
                     chk_from_year_d = 1'b0;
                  end
         S_YEAR:  if (set_edge) begin
                     next_state      = CHK;
                     chk_from_year_d = 1'b1;
                  end
         CHK:     if (bus.day_bin > dim)   next_state = FIX;
                  else if (chk_from_year)  next_state = COMMIT;
                  else                     next_state = S_YEAR;
         FIX:      next_state = FIX_WAIT;
         FIX_WAIT: next_state = CHK;
         COMMIT:   next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Values the output registers take at the next edge.
   always_comb begin
      cnt_en_d    = '0;
      cnt_up_d    = 1'b0;
      cnt_down_d  = 1'b0;
      commit_d    = 1'b0;
      field_sel_d = field_of(next_state);
      editing_d   = (next_state != IDLE);
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt;

      if (in_field && !set_edge && (up_fire ^ down_fire)) begin
         cnt_en_d   = onehot_of(state);
         cnt_up_d   = up_fire;
         cnt_down_d = down_fire;
      end
      if (state == CHK && next_state == FIX) begin
         cnt_en_d   = 5'b00100;
         cnt_down_d = 1'b1;
      end
      if (state == CHK && next_state == COMMIT) commit_d = 1'b1;

      if (next_state == IDLE || (next_state != state && field_of(next_state) != 3'd0)) begin
         blink_d     = 1'b0;
         blink_cnt_d = '0;
      end else if (blink_cnt == BW'(BLINK_TGL - 1)) begin
         blink_d     = ~blink_q;
         blink_cnt_d = '0;
      end else begin
         blink_cnt_d = blink_cnt + 1'b1;
      end
   end

   assign bus.cnt_en    = cnt_en_q;
   assign bus.cnt_up    = cnt_up_q;
   assign bus.cnt_down  = cnt_down_q;
   assign bus.field_sel = field_sel_q;
   assign bus.blink     = blink_q;
   assign bus.editing   = editing_q;
   assign bus.commit    = commit_q;

endmodule

// File: tb/tb_date_time_set_ctrl.sv
// Bench for date_time_set_ctrl: vector table for the field walk plus sequences
// for day clamping, reset mid-edit, blink timing and held buttons.
module tb_date_time_set_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   date_time_set_if bus();

   // Behavioural RTC counters driven by the controller strobes.
   logic       load;
   logic [7:0] ld_day, ld_month, ld_year;
   logic [7:0] day_m, month_m, year_m;
   int         day_dn, commits;

   typedef struct {
      logic       s, u, d;
      logic [4:0] en;
      logic       up, dn;
      logic [2:0] f;
      logic       ed, com;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   date_time_set_ctrl #(
      .CLK_HZ(40),
      .BLINK_HZ(2)
`ifdef AUTO_REPEAT_EN
      ,
      .REPEAT_DLY(20),
      .REPEAT_PER(5)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   assign bus.day_bin   = day_m;
   assign bus.month_bin = month_m;
   assign bus.year_bin  = year_m;

   always @(posedge clk) begin
      if (load) begin
         day_m   <= ld_day;
         month_m <= ld_month;
         year_m  <= ld_year;
         day_dn  <= 0;
         commits <= 0;
      end else begin
         if (bus.cnt_en[2] && bus.cnt_up)   day_m <= (day_m == 8'd31) ? 8'd1 : day_m + 8'd1;
         if (bus.cnt_en[2] && bus.cnt_down) begin
            day_m  <= (day_m == 8'd1) ? 8'd31 : day_m - 8'd1;
            day_dn <= day_dn + 1;
         end
         if (bus.cnt_en[3] && bus.cnt_up)   month_m <= (month_m == 8'd12) ? 8'd1 : month_m + 8'd1;
         if (bus.cnt_en[3] && bus.cnt_down) month_m <= (month_m == 8'd1) ? 8'd12 : month_m - 8'd1;
         if (bus.cnt_en[4] && bus.cnt_up)   year_m <= (year_m == 8'd99) ? 8'd0 : year_m + 8'd1;
         if (bus.cnt_en[4] && bus.cnt_down) year_m <= (year_m == 8'd0) ? 8'd99 : year_m - 8'd1;
         if (bus.commit) commits <= commits + 1;
      end
   end

   function automatic vec_t mk(input logic s, u, d, input logic [4:0] en, input logic up, dn,
                               input logic [2:0] f, input logic ed, com);
      vec_t v;
      v.s = s; v.u = u; v.d = d; v.en = en; v.up = up; v.dn = dn; v.f = f; v.ed = ed; v.com = com;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, u, d);
      bus.btn_set  = s;
      bus.btn_up   = u;
      bus.btn_down = d;
      tick();
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [7:0] d, m, y);
      ld_day = d; ld_month = m; ld_year = y;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic pressSet();
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic waitField(input logic [2:0] f, input string name);
      for (int i = 0; i < 50 && bus.field_sel != f; i++) tick();
      checkOutput(name, 64'(bus.field_sel), 64'(f));
   endtask

   task automatic waitIdle(input string name);
      for (int i = 0; i < 50 && bus.editing != 1'b0; i++) tick();
      checkOutput(name, 64'(bus.editing), 64'd0);
   endtask

   // From S_x, step to the year field (allowing for day fixes) and then exit.
   task automatic finishFrom(input int presses_to_year, input string name);
      for (int i = 0; i < presses_to_year; i++) pressSet();
      waitField(3'd5, {name, "_year"});
      pressSet();
      waitIdle({name, "_idle"});
   endtask

   task automatic clampCase(input logic [7:0] d, m, y, input int exp_dn, input logic [7:0] exp_day,
                            input string name);
      preload(d, m, y);
      pressSet();
      finishFrom(4, name);
      checkOutput({name, "_strobes"}, 64'(day_dn), 64'(exp_dn));
      checkOutput({name, "_day"}, 64'(day_m), 64'(exp_day));
      checkOutput({name, "_commit"}, 64'(commits), 64'd1);
   endtask

   initial begin
      logic [63:0] pat, exp_pat;
      rst = 1'b1;
      load = 1'b0;
      bus.btn_set = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
      ld_day = 8'd1; ld_month = 8'd1; ld_year = 8'd0;
      tick();
      tick();
      checkOutput("rst_outputs",
                  64'({bus.cnt_en, bus.cnt_up, bus.cnt_down, bus.field_sel, bus.blink, bus.editing, bus.commit}),
                  64'd0);
      rst = 1'b0;
      preload(8'd15, 8'd6, 8'd24);

      // s u d | en up dn field editing commit
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd0, 0,0));
      tbl.push_back(mk(1,0,0, 5'd0,  0,0, 3'd1, 1,0));
      tbl.push_back(mk(1,0,0, 5'd0,  0,0, 3'd1, 1,0));
      tbl.push_back(mk(0,1,0, 5'd1,  1,0, 3'd1, 1,0));
      tbl.push_back(mk(0,1,0, 5'd0,  0,0, 3'd1, 1,0));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd1, 1,0));
      tbl.push_back(mk(0,1,0, 5'd1,  1,0, 3'd1, 1,0));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd1, 1,0));
      tbl.push_back(mk(0,0,1, 5'd1,  0,1, 3'd1, 1,0));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd1, 1,0));
      tbl.push_back(mk(1,0,0, 5'd0,  0,0, 3'd2, 1,0));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd2, 1,0));
      tbl.push_back(mk(0,1,1, 5'd0,  0,0, 3'd2, 1,0));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd2, 1,0));
      tbl.push_back(mk(0,0,1, 5'd2,  0,1, 3'd2, 1,0));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd2, 1,0));
      tbl.push_back(mk(1,0,0, 5'd0,  0,0, 3'd3, 1,0));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd3, 1,0));
      tbl.push_back(mk(0,1,0, 5'd4,  1,0, 3'd3, 1,0));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd3, 1,0));
      tbl.push_back(mk(1,0,0, 5'd0,  0,0, 3'd4, 1,0));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd4, 1,0));
      tbl.push_back(mk(0,1,0, 5'd8,  1,0, 3'd4, 1,0));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd4, 1,0));
      tbl.push_back(mk(1,0,0, 5'd0,  0,0, 3'd0, 1,0));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd5, 1,0));
      tbl.push_back(mk(0,0,1, 5'd16, 0,1, 3'd5, 1,0));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd5, 1,0));
      tbl.push_back(mk(1,0,0, 5'd0,  0,0, 3'd0, 1,0));
      tbl.push_back(mk(0,1,0, 5'd0,  0,0, 3'd0, 1,1));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd0, 0,0));
      tbl.push_back(mk(0,1,0, 5'd0,  0,0, 3'd0, 0,0));
      tbl.push_back(mk(0,0,0, 5'd0,  0,0, 3'd0, 0,0));

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i].s, tbl[i].u, tbl[i].d);
         checkOutput($sformatf("vec%0d", i),
                     64'({bus.cnt_en, bus.cnt_up, bus.cnt_down, bus.field_sel, bus.editing, bus.commit}),
                     64'({tbl[i].en, tbl[i].up, tbl[i].dn, tbl[i].f, tbl[i].ed, tbl[i].com}));
      end
      checkOutput("tbl_day",   64'(day_m),   64'd16);
      checkOutput("tbl_month", 64'(month_m), 64'd7);
      checkOutput("tbl_year",  64'(year_m),  64'd23);
      checkOutput("tbl_commit", 64'(commits), 64'd1);

      // March 31 -> April leaves exactly one day-down fix.
      preload(8'd31, 8'd3, 8'd23);
      for (int i = 0; i < 4; i++) pressSet();
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      finishFrom(1, "apr");
      checkOutput("apr_strobes", 64'(day_dn), 64'd1);
      checkOutput("apr_day", 64'(day_m), 64'd30);
      checkOutput("apr_commit", 64'(commits), 64'd1);

      clampCase(8'd31, 8'd2, 8'd23, 3, 8'd28, "feb23");
      clampCase(8'd31, 8'd2, 8'd24, 2, 8'd29, "feb24");
      clampCase(8'd31, 8'd0, 8'd23, 0, 8'd31, "mon0");

      // Feb 29 in a leap year, year stepped back in the year field.
      preload(8'd29, 8'd2, 8'd24);
      pressSet();
      for (int i = 0; i < 4; i++) pressSet();
      waitField(3'd5, "leap_year");
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      pressSet();
      waitIdle("leap_idle");
      checkOutput("leap_strobes", 64'(day_dn), 64'd1);
      checkOutput("leap_day", 64'(day_m), 64'd28);
      checkOutput("leap_commit", 64'(commits), 64'd1);

      // Reset while in the day field, with an up press in the same cycle.
      preload(8'd10, 8'd5, 8'd20);
      for (int i = 0; i < 3; i++) pressSet();
      checkOutput("rst_mid_field", 64'(bus.field_sel), 64'd3);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("rst_mid_outputs",
                  64'({bus.cnt_en, bus.field_sel, bus.editing, bus.commit}), 64'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("rst_mid_idle", 64'(bus.editing), 64'd0);
      checkOutput("rst_mid_day", 64'(day_m), 64'd10);
      checkOutput("rst_mid_commit", 64'(commits), 64'd0);

      // Blink toggles every 10 cycles here and restarts on each field entry.
      preload(8'd10, 8'd5, 8'd20);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("blink_enter", 64'(bus.blink), 64'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (8) tick();
      checkOutput("blink_pre", 64'(bus.blink), 64'd0);
      tick();
      checkOutput("blink_toggle", 64'(bus.blink), 64'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("blink_hour", 64'({bus.field_sel, bus.blink}), 64'({3'd2, 1'b0}));
      applyStimulus(1'b0, 1'b0, 1'b0);
      finishFrom(3, "blink");
      checkOutput("blink_idle", 64'(bus.blink), 64'd0);

      // Holding up in the minute field.
      preload(8'd10, 8'd5, 8'd20);
      pressSet();
      pat = '0;
      bus.btn_up = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus.cnt_en == 5'b00001 && bus.cnt_up) pat[k] = 1'b1;
      end
      bus.btn_up = 1'b0;
      tick();
      exp_pat = '0;
      exp_pat[1] = 1'b1;
`ifdef AUTO_REPEAT_EN
      exp_pat[21] = 1'b1;
      exp_pat[26] = 1'b1;
      exp_pat[31] = 1'b1;
      exp_pat[36] = 1'b1;
`endif
      checkOutput("hold_pattern", pat, exp_pat);
      finishFrom(4, "hold");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
